// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a carry flip-flop,
// LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             c_r, c_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] sum_sh_r, sum_sh_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             carry_out_r, carry_out_s;
  logic             overflow_r, overflow_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             bit_s;
  logic             cn_s;
  logic [WIDTH:0]   shifted_s;

  // Next-state and datapath: one full-adder step per RUN cycle
  always_comb begin
    bit_s       = a_r[0] ^ b_r[0] ^ c_r;
    cn_s        = maj3(a_r[0], b_r[0], c_r);
    // Shifting through a WIDTH+1 vector keeps the WIDTH=1 case free of empty slices
    shifted_s   = {bit_s, sum_sh_r} >> 1'b1;

    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    c_s         = c_r;
    cnt_s       = cnt_r;
    sum_sh_s    = sum_sh_r;
    sum_s       = sum_r;
    carry_out_s = carry_out_r;
    overflow_s  = overflow_r;
    busy_s      = busy_r;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry
          a_s     = a;
          b_s     = sub ? ~b : b;
          c_s     = sub;
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b1;
          state_s = RUN;
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      RUN: begin
        a_s      = a_r >> 1'b1;
        b_s      = b_r >> 1'b1;
        c_s      = cn_s;
        cnt_s    = cnt_r + CW'(1);
        sum_sh_s = shifted_s[WIDTH-1:0];
        if (cnt_r == LAST_BIT) begin
          // Signed overflow: carry into the MSB differs from carry out of it
          sum_s       = shifted_s[WIDTH-1:0];
          carry_out_s = cn_s;
          overflow_s  = c_r ^ cn_s;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          state_s     = IDLE;
        end else begin
          busy_s  = 1'b1;
          state_s = RUN;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      c_r         <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      sum_sh_r    <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      c_r         <= c_s;
      cnt_r       <= cnt_s;
      sum_sh_r    <= sum_sh_s;
      sum_r       <= sum_s;
      carry_out_r <= carry_out_s;
      overflow_r  <= overflow_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: WIDTH=8 and WIDTH=1 instances checked
// against an arithmetic reference model with directed and random operations.
module tb_serial_adder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, carry_out, overflow;
  logic [7:0] sum;

  logic       start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1, carry_out1, overflow1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  serial_adder_n #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry_out1), .overflow(overflow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic and sign-rule overflow
  function automatic void model(input int w, input int ia, input int ib, input bit isub,
                                output int s, output bit co, output bit ov);
    int mask, bb, full, sa, sb, ss;
    mask = (1 << w) - 1;
    bb   = isub ? ((~ib) & mask) : ib;
    full = ia + bb + (isub ? 1 : 0);
    s    = full & mask;
    co   = ((full >> w) & 1) == 1;
    sa   = (ia >> (w - 1)) & 1;
    sb   = (ib >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    if (isub) ov = (sa != sb) && (ss != sa);
    else      ov = (sa == sb) && (ss != sa);
  endfunction

  // mode 0: plain op; 1: start re-pulsed and operands toggled while busy; 2: reset at cycle 4
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                     input int mode, input string tag);
    int  cyc, bcnt, es, extra;
    bit  eco, eov, got;
    model(8, int'(ta), int'(tb), ts, es, eco, eov);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; bcnt = 0; got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) begin
        if (cyc == 3) begin
          start = 1'b1; a = 8'h00;
        end else begin
          a = ~a;
        end
        if (cyc == 4) start = 1'b0;
        b = ~b;
      end
      if (mode == 2 && cyc == 4) begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_sum"}, 32'(sum), 32'd0);
        check({tag, "_rst_co"}, 32'(carry_out), 32'd0);
        check({tag, "_rst_ov"}, 32'(overflow), 32'd0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (done || busy) extra++;
        end
        check({tag, "_no_done_after_rst"}, 32'(extra), 32'd0);
        return;
      end
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(cyc - 1), 32'd8);
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_co"}, 32'(carry_out), 32'(eco));
      check({tag, "_ov"}, 32'(overflow), 32'(eov));
    end
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({tag, "_single_done"}, 32'(extra), 32'd0);
      check({tag, "_sum_held"}, 32'(sum), 32'(es));
    end
  endtask

  task automatic op1(input logic ta, input logic tb, input logic ts, input string tag);
    int cyc, bcnt, es;
    bit eco, eov, got;
    model(1, int'(ta), int'(tb), ts, es, eco, eov);
    a1 = ta; b1 = tb; sub1 = ts; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cyc = 0; bcnt = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (busy1) bcnt++;
      if (done1) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(cyc - 1), 32'd1);
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'd1);
      check({tag, "_sum"}, 32'(sum1), 32'(es));
      check({tag, "_co"}, 32'(carry_out1), 32'(eco));
      check({tag, "_ov"}, 32'(overflow1), 32'(eov));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    start1 = 1'b0; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(carry_out), 32'd0);
    check("rst_ov", 32'(overflow), 32'd0);
    check("rst1_busy", 32'(busy1), 32'd0);
    check("rst1_done", 32'(done1), 32'd0);

    // Reset must win over a simultaneous start
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    check("rst_wins_busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_wins_idle", 32'(busy), 32'd0);

    op8(8'h5A, 8'h3C, 1'b0, 0, "add_5a_3c");
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("sum_hold", 32'(sum), 32'h96);

    op8(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    @(negedge clk);
    op8(8'h10, 8'h20, 1'b1, 0, "sub_10_20");
    op8(8'h80, 8'h01, 1'b1, 0, "b2b_sub_80_01");
    repeat (2) @(negedge clk);

    op8(8'hC3, 8'h7E, 1'b0, 1, "ignore_start");
    a = 8'h00; b = 8'h00;
    @(negedge clk);
    op8(8'h12, 8'h34, 1'b0, 2, "abort");
    op8(8'h12, 8'h34, 1'b0, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, "rand8");
    end

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      @(negedge clk);
      op1(ab[1], ab[0], 1'b0, "w1_half_add");
      check("w1_sum_xor", 32'(sum1), 32'(ab[1] ^ ab[0]));
      check("w1_co_and", 32'(carry_out1), 32'(ab[1] & ab[0]));
    end
    for (int i = 0; i < 8; i++) begin
      op1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "w1_rand");
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
